// File: rtl/data_buffer_pkg.sv
// Shared definitions for the data buffer op interface.
// The buffer controller and the storage FIFO both import this package.
package data_buffer_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } op_type_e;

  localparam int DEPTH_DEFAULT = 64;

endpackage

// File: rtl/buffer_ptr_counter.sv
// Modulo-2^ADDR_W pointer with count enable and synchronous clear.
// The pointer wraps from all-ones back to zero with no gap.
module buffer_ptr_counter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              count_enable,
  input  logic              clear,
  output logic [ADDR_W-1:0] count
);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  // Clear has priority; the natural binary rollover provides the wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/data_buffer_fifo.sv
// Byte circular buffer with first-word-fall-through read data, occupancy
// tracking, full/empty status and one-cycle overflow/underflow pulses.
module data_buffer_fifo
  import data_buffer_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [1:0]       op,
  input  logic [7:0]       write_data,
  input  logic             write_count_enable,
  input  logic             read_count_enable,
  input  logic             empty_buffer,
  output logic [7:0]       read_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             buffer_full,
  output logic             buffer_empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;

  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              underflow_q;
  logic              underflow_d;

  logic              wr_req;
  logic              rd_req;
  logic              wr_accept;
  logic              rd_accept;

  assign buffer_full  = (occ_q == OCC_W'(DEPTH));
  assign buffer_empty = (occ_q == '0);

  assign wr_req    = (op == WRITE) && write_count_enable;
  assign rd_req    = (op == READ) && read_count_enable;
  assign wr_accept = wr_req && !buffer_full && !empty_buffer;
  assign rd_accept = rd_req && !buffer_empty && !empty_buffer;

  // A flush wins over any request in the same cycle and masks its error pulse.
  always_comb begin
    occ_d       = occ_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (empty_buffer) begin
      occ_d = '0;
    end else begin
      if (wr_accept) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (rd_accept) begin
        occ_d = occ_q - OCC_W'(1);
      end
      overflow_d  = wr_req && buffer_full;
      underflow_d = rd_req && buffer_empty;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      occ_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wptr] <= write_data;
    end
  end

  buffer_ptr_counter #(.ADDR_W(ADDR_W)) u_wptr (
    .clk          (clk),
    .n_rst        (n_rst),
    .count_enable (wr_accept),
    .clear        (empty_buffer),
    .count        (wptr)
  );

  buffer_ptr_counter #(.ADDR_W(ADDR_W)) u_rptr (
    .clk          (clk),
    .n_rst        (n_rst),
    .count_enable (rd_accept),
    .clear        (empty_buffer),
    .count        (rptr)
  );

  assign read_data        = buffer_empty ? 8'h00 : mem[rptr];
  assign buffer_occupancy = occ_q;
  assign overflow_err     = overflow_q;
  assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_data_buffer_fifo.sv
// Directed bench for data_buffer_fifo: a queue-based reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_data_buffer_fifo;

  localparam int DEPTH = 64;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic [1:0]       op = 2'd0;
  logic [7:0]       write_data = 8'h00;
  logic             write_count_enable = 1'b0;
  logic             read_count_enable = 1'b0;
  logic             empty_buffer = 1'b0;
  logic [7:0]       read_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic             buffer_full;
  logic             buffer_empty;
  logic             overflow_err;
  logic             underflow_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;
  logic       model_unf = 1'b0;

  data_buffer_fifo #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .op                 (op),
    .write_data         (write_data),
    .write_count_enable (write_count_enable),
    .read_count_enable  (read_count_enable),
    .empty_buffer       (empty_buffer),
    .read_data          (read_data),
    .buffer_occupancy   (buffer_occupancy),
    .buffer_full        (buffer_full),
    .buffer_empty       (buffer_empty),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [7:0] d,
                               input logic wce, input logic rce, input logic eb);
    @(posedge clk);
    #1;
    op                 = o;
    write_data         = d;
    write_count_enable = wce;
    read_count_enable  = rce;
    empty_buffer       = eb;
  endtask

  task automatic doIdle();
    applyStimulus(2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doWrite(input logic [7:0] d);
    applyStimulus(2'd1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doRead();
    applyStimulus(2'd2, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // Reference model: a byte queue updated by the rules of the op interface.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      model_ovf = 1'b0;
      model_unf = 1'b0;
      if (empty_buffer) begin
        model_q.delete();
      end else if (op == 2'd1 && write_count_enable) begin
        if (model_q.size() == DEPTH) model_ovf = 1'b1;
        else model_q.push_back(write_data);
      end else if (op == 2'd2 && read_count_enable) begin
        if (model_q.size() == 0) model_unf = 1'b1;
        else void'(model_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model_read_data", int'(read_data),
                (model_q.size() != 0) ? int'(model_q[0]) : 0);
    checkOutput("model_occupancy", int'(buffer_occupancy), model_q.size());
    checkOutput("model_full", int'(buffer_full), int'(model_q.size() == DEPTH));
    checkOutput("model_empty", int'(buffer_empty), int'(model_q.size() == 0));
    checkOutput("model_overflow", int'(overflow_err), int'(model_ovf));
    checkOutput("model_underflow", int'(underflow_err), int'(model_unf));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    n_rst = 1'b1;
    doIdle();
    @(negedge clk);
    checkOutput("reset_occupancy", int'(buffer_occupancy), 0);
    checkOutput("reset_empty", int'(buffer_empty), 1);
    checkOutput("reset_full", int'(buffer_full), 0);
    checkOutput("reset_read_data", int'(read_data), 0);

    // Three writes then three in-order reads.
    doWrite(8'hA5);
    doWrite(8'h3C);
    doWrite(8'hFF);
    doIdle();
    @(negedge clk);
    checkOutput("three_occupancy", int'(buffer_occupancy), 3);
    checkOutput("three_empty", int'(buffer_empty), 0);
    doRead(); @(negedge clk); checkOutput("read_a5", int'(read_data), 8'hA5);
    doRead(); @(negedge clk); checkOutput("read_3c", int'(read_data), 8'h3C);
    doRead(); @(negedge clk); checkOutput("read_ff", int'(read_data), 8'hFF);
    doIdle(); @(negedge clk);
    checkOutput("drained_occupancy", int'(buffer_occupancy), 0);

    // Fill, overflow attempt, full readout.
    for (int i = 0; i < DEPTH; i++) doWrite(8'(i));
    doIdle(); @(negedge clk);
    checkOutput("fill_full", int'(buffer_full), 1);
    checkOutput("fill_occupancy", int'(buffer_occupancy), 64);
    doWrite(8'h99);
    doIdle(); @(negedge clk);
    checkOutput("overflow_pulse", int'(overflow_err), 1);
    checkOutput("overflow_occupancy", int'(buffer_occupancy), 64);
    doIdle(); @(negedge clk);
    checkOutput("overflow_pulse_end", int'(overflow_err), 0);
    for (int i = 0; i < DEPTH; i++) begin
      doRead(); @(negedge clk);
      checkOutput("full_readout", int'(read_data), i);
    end
    doIdle(); @(negedge clk);
    checkOutput("readout_empty", int'(buffer_empty), 1);

    // Read while empty.
    doRead(); @(negedge clk);
    checkOutput("underflow_read_data", int'(read_data), 0);
    doIdle(); @(negedge clk);
    checkOutput("underflow_pulse", int'(underflow_err), 1);
    checkOutput("underflow_occupancy", int'(buffer_occupancy), 0);
    doIdle(); @(negedge clk);
    checkOutput("underflow_pulse_end", int'(underflow_err), 0);

    // Mismatched enable and reserved op are ignored.
    applyStimulus(2'd1, 8'h11, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'd3, 8'h22, 1'b1, 1'b1, 1'b0);
    doIdle(); @(negedge clk);
    checkOutput("ignored_ops", int'(buffer_occupancy), 0);

    // Pointer wrap: pointers sit at 3, so 60 more lands them at 63.
    for (int i = 0; i < 60; i++) doWrite(8'(i + 100));
    for (int i = 0; i < 60; i++) doRead();
    for (int i = 0; i < 10; i++) doWrite(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      doRead(); @(negedge clk);
      checkOutput("wrap_readout", int'(read_data), 8'h10 + i);
    end
    doIdle(); @(negedge clk);
    checkOutput("wrap_occupancy", int'(buffer_occupancy), 0);

    // Flush with a simultaneous write.
    for (int i = 0; i < 5; i++) doWrite(8'(8'h60 + i));
    applyStimulus(2'd1, 8'h77, 1'b1, 1'b0, 1'b1);
    doIdle(); @(negedge clk);
    checkOutput("flush_occupancy", int'(buffer_occupancy), 0);
    checkOutput("flush_empty", int'(buffer_empty), 1);
    checkOutput("flush_no_overflow", int'(overflow_err), 0);
    doWrite(8'h42);
    doRead(); @(negedge clk);
    checkOutput("after_flush_read", int'(read_data), 8'h42);

    // Asynchronous reset during a write.
    doWrite(8'h01); doWrite(8'h02); doWrite(8'h03);
    doWrite(8'hEE);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("async_occupancy", int'(buffer_occupancy), 0);
    checkOutput("async_read_data", int'(read_data), 0);
    checkOutput("async_empty", int'(buffer_empty), 1);
    doIdle();
    @(negedge clk);
    n_rst = 1'b1;
    doIdle(); @(negedge clk);
    checkOutput("post_reset_occupancy", int'(buffer_occupancy), 0);
    doWrite(8'h55);
    doRead(); @(negedge clk);
    checkOutput("post_reset_read", int'(read_data), 8'h55);
    doIdle(); @(negedge clk);
    checkOutput("post_reset_drained", int'(buffer_occupancy), 0);

    doIdle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
